// File: rtl/rgb_gray_pkg.sv
// +--------------------------------------------------------------------------+
// | rgb_gray_pkg: luma coefficients, pixel layout and mean reciprocal helper |
// | rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none
`timescale 1ns/1ps

package rgb_gray_pkg;

  localparam int LANES        = 4;
  localparam int PIX_PER_BEAT = 4;

  localparam int COEF_R  = 77;
  localparam int COEF_G  = 150;
  localparam int COEF_B  = 29;
  localparam int Y_ROUND = 128;
  localparam int S_ROUND = 2;

  localparam int R_OFS = 16;
  localparam int G_OFS = 8;
  localparam int B_OFS = 0;

  localparam int MEAN_ACC_W = 26;

  // Shift that makes floor(acc*m >> shift) exact for every acc below 2^MEAN_ACC_W.
  function automatic int mean_shift(input logic [63:0] n);
    return MEAN_ACC_W + $clog2(n);
  endfunction

  function automatic logic [63:0] mean_recip(input logic [63:0] n, input int shift);
    logic [63:0] one_sh;
    one_sh = 64'd1 << shift;
    return (one_sh + n - 64'd1) / n;
  endfunction

endpackage

`default_nettype wire

// File: rtl/rgb_gray_luma4.sv
// +--------------------------------------------------------------------------+
// | rgb_gray_luma4: 4 ARGB pixels -> rounded average of their 8-bit luma     |
// | rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none
`timescale 1ns/1ps

module rgb_gray_luma4
  import rgb_gray_pkg::*;
(
  input  logic [127:0] i_beat,
  output logic [7:0]   o_sample
);

  logic [7:0] w_y [PIX_PER_BEAT];
  logic [9:0] w_sum;
  logic       w_unused_alpha;

  for (genvar k = 0; k < PIX_PER_BEAT; k++) begin : g_pix
    logic [7:0]  w_r;
    logic [7:0]  w_g;
    logic [7:0]  w_b;
    logic [15:0] w_acc;

    assign w_r   = i_beat[32*k+R_OFS +: 8];
    assign w_g   = i_beat[32*k+G_OFS +: 8];
    assign w_b   = i_beat[32*k+B_OFS +: 8];
    // Coefficients sum to 256, so the rounded sum never exceeds 16 bits.
    assign w_acc = 16'(COEF_R) * {8'd0, w_r} + 16'(COEF_G) * {8'd0, w_g}
                 + 16'(COEF_B) * {8'd0, w_b} + 16'(Y_ROUND);
    assign w_y[k] = 8'(w_acc >> 8);
  end

  assign w_sum = {2'b00, w_y[0]} + {2'b00, w_y[1]} + {2'b00, w_y[2]}
               + {2'b00, w_y[3]} + 10'(S_ROUND);
  assign o_sample = 8'(w_sum >> 2);

  assign w_unused_alpha = ^{i_beat[127:120], i_beat[95:88], i_beat[63:56], i_beat[31:24]};

endmodule

`default_nettype wire

// File: rtl/rgb_gray_decimator.sv
// +--------------------------------------------------------------------------+
// | rgb_gray_decimator: ARGB 4-pix beats -> 4x/ROW_DECIM decimated luma      |
// | stream. Optional frame mean: RGB_GRAY_DECIMATOR_MEAN_EN. rev 1.0         |
// +--------------------------------------------------------------------------+
`default_nettype none
`timescale 1ns/1ps

module rgb_gray_decimator
  import rgb_gray_pkg::*;
#(
  parameter int IMG_WIDTH  = 1920,
  parameter int IMG_HEIGHT = 1080,
  parameter int ROW_DECIM  = 4
) (
  input  logic         I_clk,
  input  logic         I_rst_n,
  input  logic [127:0] I_tdata,
  input  logic         I_tvalid,
  input  logic         I_tuser,
  input  logic         I_tlast,
  output logic         I_tready,
  output logic [31:0]  O_tdata,
  output logic         O_tvalid,
  output logic         O_tuser,
  output logic         O_tlast,
`ifdef RGB_GRAY_DECIMATOR_MEAN_EN
  output logic [7:0]   O_frame_mean,
`endif
  input  logic         O_tready
);

  localparam int              ROW_W      = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
  localparam logic [ROW_W-1:0] DECIM_MASK = ROW_W'(ROW_DECIM - 1);
  localparam logic [ROW_W-1:0] LAST_ROW   = ROW_W'(IMG_HEIGHT - 1);

  logic [ROW_W-1:0] row_cnt_q, row_cnt_d;
  logic [1:0]       lane_cnt_q, lane_cnt_d;
  logic [31:0]      pack_q, pack_d;
  logic [31:0]      out_data_q, out_data_d;
  logic             out_valid_q, out_valid_d;
  logic             out_user_q, out_user_d;
  logic             out_last_q, out_last_d;
  logic             sof_pending_q, sof_pending_d;

  logic [7:0]       w_sample;
  logic             w_sof;
  logic             w_row_kept;
  logic             w_accept;
  logic             w_complete;
  logic [ROW_W-1:0] w_row_base;
  logic [1:0]       w_lane;
  logic [31:0]      w_pack_new;

  rgb_gray_luma4 u_luma4 (
    .i_beat   (I_tdata),
    .o_sample (w_sample)
  );

  // A start-of-frame beat is row 0 by definition, so it is always kept.
  assign w_sof      = I_tvalid && I_tuser;
  assign w_row_base = w_sof ? '0 : row_cnt_q;
  assign w_row_kept = w_sof || ((row_cnt_q & DECIM_MASK) == '0);
  assign I_tready   = w_row_kept ? (!out_valid_q || O_tready) : 1'b1;
  assign w_accept   = I_tvalid && I_tready;
  assign w_lane     = w_sof ? 2'd0 : lane_cnt_q;
  assign w_complete = w_accept && w_row_kept && ((w_lane == 2'(LANES - 1)) || I_tlast);

  always_comb begin
    w_pack_new = w_sof ? 32'd0 : pack_q;
    w_pack_new[{w_lane, 3'b000} +: 8] = w_sample;
  end

  always_comb begin
    row_cnt_d     = row_cnt_q;
    lane_cnt_d    = lane_cnt_q;
    pack_d        = pack_q;
    out_data_d    = out_data_q;
    out_valid_d   = out_valid_q;
    out_user_d    = out_user_q;
    out_last_d    = out_last_q;
    sof_pending_d = sof_pending_q;

    if (out_valid_q && O_tready) begin
      out_valid_d = 1'b0;
    end

    if (w_accept) begin
      if (w_sof) begin
        row_cnt_d     = '0;
        lane_cnt_d    = 2'd0;
        pack_d        = 32'd0;
        sof_pending_d = 1'b1;
      end
      if (I_tlast) begin
        row_cnt_d = (w_row_base == LAST_ROW) ? '0 : w_row_base + ROW_W'(1);
      end
      if (w_complete) begin
        // A new pack overrides the beat being drained this cycle.
        out_data_d    = w_pack_new;
        out_valid_d   = 1'b1;
        out_user_d    = sof_pending_q || w_sof;
        out_last_d    = I_tlast;
        pack_d        = 32'd0;
        lane_cnt_d    = 2'd0;
        sof_pending_d = 1'b0;
      end else if (w_row_kept) begin
        pack_d     = w_pack_new;
        lane_cnt_d = w_lane + 2'd1;
      end
    end
  end

  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      row_cnt_q     <= '0;
      lane_cnt_q    <= 2'd0;
      pack_q        <= 32'd0;
      out_data_q    <= 32'd0;
      out_valid_q   <= 1'b0;
      out_user_q    <= 1'b0;
      out_last_q    <= 1'b0;
      sof_pending_q <= 1'b0;
    end else begin
      row_cnt_q     <= row_cnt_d;
      lane_cnt_q    <= lane_cnt_d;
      pack_q        <= pack_d;
      out_data_q    <= out_data_d;
      out_valid_q   <= out_valid_d;
      out_user_q    <= out_user_d;
      out_last_q    <= out_last_d;
      sof_pending_q <= sof_pending_d;
    end
  end

  assign O_tdata  = out_data_q;
  assign O_tvalid = out_valid_q;
  assign O_tuser  = out_user_q;
  assign O_tlast  = out_last_q;

`ifdef RGB_GRAY_DECIMATOR_MEAN_EN
  localparam logic [63:0] MEAN_N     = 64'((IMG_WIDTH / PIX_PER_BEAT) * (IMG_HEIGHT / ROW_DECIM));
  localparam int          MEAN_SHIFT = mean_shift(MEAN_N);
  localparam logic [33:0] MEAN_MULT  = 34'(mean_recip(MEAN_N, MEAN_SHIFT));

  logic [MEAN_ACC_W-1:0] mean_acc_q, mean_acc_d;
  logic [7:0]            frame_mean_q, frame_mean_d;
  logic [MEAN_ACC_W-1:0] w_acc_sum;
  logic [59:0]           w_mean_prod;

  assign w_acc_sum   = (w_sof ? '0 : mean_acc_q)
                     + (w_row_kept ? {18'd0, w_sample} : 26'd0);
  assign w_mean_prod = {34'd0, w_acc_sum} * {26'd0, MEAN_MULT};

  always_comb begin
    mean_acc_d   = mean_acc_q;
    frame_mean_d = frame_mean_q;
    if (w_accept) begin
      mean_acc_d = w_acc_sum;
      if (I_tlast && (w_row_base == LAST_ROW)) begin
        frame_mean_d = 8'(w_mean_prod >> MEAN_SHIFT);
        mean_acc_d   = '0;
      end
    end
  end

  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      mean_acc_q   <= '0;
      frame_mean_q <= 8'd0;
    end else begin
      mean_acc_q   <= mean_acc_d;
      frame_mean_q <= frame_mean_d;
    end
  end

  assign O_frame_mean = frame_mean_q;
`else
  // Frame statistics are left to the downstream engine in this build.
`endif

endmodule

`default_nettype wire

// File: tb/tb_rgb_gray_decimator.sv
// +--------------------------------------------------------------------------+
// | tb_rgb_gray_decimator: directed checks on a 64x12 frame, ROW_DECIM=4     |
// | rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none
`timescale 1ns/1ps

module tb_rgb_gray_decimator;

  localparam int W     = 64;
  localparam int H     = 12;
  localparam int D     = 4;
  localparam int BEATS = W / 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [127:0] tdata = '0;
  logic         tvalid = 1'b0;
  logic         tuser = 1'b0;
  logic         tlast = 1'b0;
  logic         tready;
  logic [31:0]  o_tdata;
  logic         o_tvalid;
  logic         o_tuser;
  logic         o_tlast;
  logic         o_tready;
`ifdef RGB_GRAY_DECIMATOR_MEAN_EN
  logic [7:0]   o_frame_mean;
`endif

  logic         ready_man = 1'b1;
  logic         bp_mode = 1'b0;
  logic [3:0]   bp_pat = 4'b1001;
  int           cyc = 0;
  int           stall_cnt = 0;
  int           n_pass = 0;
  int           n_total = 0;
  logic [33:0]  outq[$];
  logic         prev_stall = 1'b0;
  logic [33:0]  prev_beat = '0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  assign o_tready = bp_mode ? bp_pat[cyc[1:0]] : ready_man;

  rgb_gray_decimator #(
    .IMG_WIDTH  (W),
    .IMG_HEIGHT (H),
    .ROW_DECIM  (D)
  ) dut (
    .I_clk        (clk),
    .I_rst_n      (rst_n),
    .I_tdata      (tdata),
    .I_tvalid     (tvalid),
    .I_tuser      (tuser),
    .I_tlast      (tlast),
    .I_tready     (tready),
    .O_tdata      (o_tdata),
    .O_tvalid     (o_tvalid),
    .O_tuser      (o_tuser),
    .O_tlast      (o_tlast),
`ifdef RGB_GRAY_DECIMATOR_MEAN_EN
    .O_frame_mean (o_frame_mean),
`endif
    .O_tready     (o_tready)
  );

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Transfers are recorded half a cycle before the edge that completes them.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall)
        check_eq("stall_hold", {o_tvalid, o_tuser, o_tlast, o_tdata}, {1'b1, prev_beat});
      if (o_tvalid && o_tready) outq.push_back({o_tuser, o_tlast, o_tdata});
      prev_stall = o_tvalid && !o_tready;
      prev_beat  = {o_tuser, o_tlast, o_tdata};
    end
  end

  function automatic logic [31:0] gray(input logic [7:0] v);
    return {8'hFF, v, v, v};
  endfunction

  function automatic logic [127:0] g4(input logic [7:0] v);
    return {4{gray(v)}};
  endfunction

  task automatic send_beat(input logic [127:0] d, input logic u, input logic l, input logic want_free);
    int n = 0;
    tdata = d; tuser = u; tlast = l; tvalid = 1'b1;
    @(negedge clk);
    if (want_free) check_eq("drop_row_tready", tready, 1);
    while (!tready && n < 200) begin
      stall_cnt++; n++;
      @(negedge clk);
    end
    if (!tready) check_eq("accept_timeout", tready, 1);
    @(posedge clk); #1;
    tvalid = 1'b0; tuser = 1'b0; tlast = 1'b0;
  endtask

  task automatic send_frame(input logic [127:0] d, input logic drop_chk);
    for (int r = 0; r < H; r++)
      for (int b = 0; b < BEATS; b++)
        send_beat(d, (r == 0) && (b == 0), b == BEATS - 1, drop_chk && (r % D != 0));
  endtask

  task automatic wait_out(input int n);
    int k = 0;
    while (outq.size() < n && k < 300) begin
      @(posedge clk); k++;
    end
    repeat (3) @(posedge clk);
    #1;
    check_eq("out_count", outq.size(), n);
  endtask

  task automatic check_frame(input string tag, input logic [7:0] s);
    wait_out(12);
    for (int i = 0; i < 12 && outq.size() > 0; i++)
      check_eq(tag, outq.pop_front(), {i == 0, i % 4 == 3, {4{s}}});
    outq.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [33:0] exp_q[$];

    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    check_eq("rst_tvalid", o_tvalid, 0);
    check_eq("rst_tuser", o_tuser, 0);
    check_eq("rst_tlast", o_tlast, 0);
    check_eq("rst_tdata", o_tdata, 0);
    check_eq("rst_tready", tready, 1);
`ifdef RGB_GRAY_DECIMATOR_MEAN_EN
    check_eq("rst_mean", o_frame_mean, 0);
`endif

    // Red frame interrupted by reset in row 5 with an output beat stalled.
    for (int r = 0; r < 5; r++)
      for (int b = 0; b < BEATS; b++)
        send_beat(g4(8'h00) | {4{32'h00FF0000}}, (r == 0) && (b == 0), b == BEATS - 1, 1'b0);
    ready_man = 1'b0;
    for (int b = 0; b < 3; b++) send_beat({4{32'hFFFF0000}}, 1'b0, 1'b0, 1'b1);
    check_eq("stalled_before_reset", o_tvalid, 1);
    #2 rst_n = 1'b0;
    #1;
    check_eq("async_rst_tvalid", o_tvalid, 0);
    check_eq("async_rst_tdata", o_tdata, 0);
    check_eq("red_count", outq.size(), 7);
    for (int i = 0; i < 7 && outq.size() > 0; i++)
      check_eq("red", outq.pop_front(), {i == 0, i == 3, 32'h4D4D4D4D});
    outq.delete();
    ready_man = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Clean white frame after reset, no backpressure.
    stall_cnt = 0;
    send_frame(g4(8'hFF), 1'b0);
    check_eq("no_input_stall", stall_cnt, 0);
`ifdef RGB_GRAY_DECIMATOR_MEAN_EN
    check_eq("mean_white", o_frame_mean, 8'hFF);
`endif
    check_frame("white", 8'hFF);

    // Red/green/blue/white pixels (Y=77,149,29,255) under 1-0-0-1 backpressure.
    bp_mode = 1'b1;
    send_frame({32'hFFFFFFFF, 32'hFF0000FF, 32'hFF00FF00, 32'hFFFF0000}, 1'b1);
`ifdef RGB_GRAY_DECIMATOR_MEAN_EN
    check_eq("mean_rgbw", o_frame_mean, 8'h80);
`endif
    check_frame("bp_rgbw", 8'h80);
    @(posedge clk); #1;
    bp_mode = 1'b0;
    outq.delete();

    // Short line, stalled output across dropped rows, early frame start.
    send_beat({gray(8'h0D), gray(8'h0C), gray(8'h0B), gray(8'h0A)}, 1'b1, 1'b0, 1'b0);
    send_beat(g4(8'h22), 1'b0, 1'b0, 1'b0);
    send_beat(g4(8'h33), 1'b0, 1'b0, 1'b0);
    send_beat(g4(8'h44), 1'b0, 1'b0, 1'b0);
    send_beat(g4(8'h55), 1'b0, 1'b1, 1'b0);
    ready_man = 1'b0;
    for (int r = 1; r < 4; r++) send_beat(g4(8'h01), 1'b0, 1'b1, 1'b1);
    tdata = g4(8'h66); tvalid = 1'b1;
    @(negedge clk);
    check_eq("kept_row_stalled", tready, 0);
    tvalid = 1'b0;
    @(posedge clk); #1 ready_man = 1'b1;
    @(posedge clk); #1;
    send_beat(g4(8'h66), 1'b0, 1'b0, 1'b0);
    send_beat(g4(8'h77), 1'b0, 1'b0, 1'b0);
    send_beat(g4(8'h99), 1'b1, 1'b0, 1'b0);
    send_beat(g4(8'hAA), 1'b0, 1'b0, 1'b0);
    send_beat(g4(8'hBB), 1'b0, 1'b0, 1'b0);
    send_beat(g4(8'hCC), 1'b0, 1'b1, 1'b0);
    for (int b = 0; b < 4; b++) send_beat(g4(8'h10), 1'b0, b == 3, 1'b1);
    for (int r = 2; r < 4; r++) send_beat(g4(8'h01), 1'b0, 1'b1, 1'b1);
    send_beat(g4(8'hEE), 1'b0, 1'b1, 1'b0);

    exp_q = '{{2'b10, 32'h4433220C}, {2'b01, 32'h00000055},
              {2'b11, 32'hCCBBAA99}, {2'b01, 32'h000000EE}};
    wait_out(4);
    for (int i = 0; i < 4 && outq.size() > 0; i++)
      check_eq("short_early", outq.pop_front(), exp_q[i]);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
